// File: rtl/regfile_2r1w_sb_pkg.sv
// Shared sizing constants and small helpers for the integer register file
// and its pending-write scoreboard.
package regfile_2r1w_sb_pkg;

  // Data word width of the core.
  localparam int XLEN = 32;

  // Number of architectural integer registers.
  localparam int NREG = 32;

  // Register address width, log2(NREG).
  localparam int AW   = 5;

  // True when the address names the hard-wired zero register x0.
  function automatic logic is_x0(input logic [AW-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_2r1w_sb_rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// multi-cycle producer is issued and cleared when its writeback lands.
// A flush drops every outstanding bit, but an issue in the same cycle still
// sets its bit because that instruction belongs to the post-flush stream.
module rf_scoreboard
  import regfile_2r1w_sb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic            flush_i,
  output logic [NREG-1:0] pending_o
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Next pending vector: flush first, then writeback clear, then issue set,
  // so a same-address issue overrides the writeback (newer producer wins).
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end
    if (we_i && !is_x0(rd_addr_i)) begin
      pending_d[rd_addr_i] = 1'b0;
    end
    if (issue_valid_i && !is_x0(issue_rd_i)) begin
      pending_d[issue_rd_i] = 1'b1;
    end
  end

  // Pending vector state; reset beats every other event in the cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// RV32I integer register file: 32 x 32-bit, two combinational read ports
// for ID with write-first bypass from WB, one synchronous write port, and
// busy flags from the pending-write scoreboard so ID can stall on operands
// still owed by loads or mul/div.
module regfile_2r1w_sb
  import regfile_2r1w_sb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pending;
  logic            rs1_hit;
  logic            rs2_hit;

  rf_scoreboard u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .we_i          (we),
    .rd_addr_i     (rd_addr),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .flush_i       (flush),
    .pending_o     (pending)
  );

  // Register array write port; x0 is never written so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && !is_x0(rd_addr)) begin
      regs_q[rd_addr] <= rd_data;
    end
  end

  assign rs1_hit = we && (rd_addr == rs1_addr);
  assign rs2_hit = we && (rd_addr == rs2_addr);

  // Read port 1: x0 reads zero, otherwise WB data bypasses the array, and a
  // same-cycle writeback releases the stall immediately.
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (!is_x0(rs1_addr)) begin
      rs1_data = rs1_hit ? rd_data : regs_q[rs1_addr];
      rs1_busy = pending[rs1_addr] && !rs1_hit;
    end
  end

  // Read port 2: identical policy to port 1.
  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (!is_x0(rs2_addr)) begin
      rs2_data = rs2_hit ? rd_data : regs_q[rs2_addr];
      rs2_busy = pending[rs2_addr] && !rs2_hit;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Self-checking bench for regfile_2r1w_sb: an array/bit-vector model of the
// architectural state, a per-cycle compare on the falling edge, and directed
// scenarios with literal expectations.
module tb_regfile_2r1w_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1Addr;
  logic [4:0]  rs2Addr;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        rs1Busy;
  logic        rs2Busy;
  logic        we;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;
  logic        issueValid;
  logic [4:0]  issueRd;
  logic        flush;

  int total = 0;
  int bad   = 0;

  logic [31:0] modelRegs [32];
  bit          modelPend [32];
  bit          modelValid = 0;

  regfile_2r1w_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1Addr),
    .rs2_addr    (rs2Addr),
    .rs1_data    (rs1Data),
    .rs2_data    (rs2Data),
    .rs1_busy    (rs1Busy),
    .rs2_busy    (rs2Busy),
    .we          (we),
    .rd_addr     (rdAddr),
    .rd_data     (rdData),
    .issue_valid (issueValid),
    .issue_rd    (issueRd),
    .flush       (flush)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [4:0] rd, input logic [31:0] d,
                               input logic iv, input logic [4:0] ird, input logic fl,
                               input logic [4:0] a1, input logic [4:0] a2);
    rst = r; we = w; rdAddr = rd; rdData = d;
    issueValid = iv; issueRd = ird; flush = fl;
    rs1Addr = a1; rs2Addr = a2;
  endtask

  // Advance to the next input-drive point, 2 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] expData(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && rdAddr == a) return rdData;
    return modelRegs[a];
  endfunction

  function automatic logic expBusy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (we && rdAddr == a) return 1'b0;
    return modelPend[a];
  endfunction

  // Architectural model: commits the cycle's events at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        modelRegs[i] = 32'h0;
        modelPend[i] = 1'b0;
      end
      modelValid = 1;
    end else begin
      if (flush) begin
        for (int i = 0; i < 32; i++) modelPend[i] = 1'b0;
      end
      if (we && rdAddr != 0) begin
        modelRegs[rdAddr] = rdData;
        modelPend[rdAddr] = 1'b0;
      end
      if (issueValid && issueRd != 0) modelPend[issueRd] = 1'b1;
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("rs1_data", rs1Data, expData(rs1Addr));
      checkOutput("rs2_data", rs2Data, expData(rs2Addr));
      checkOutput("rs1_busy", {31'b0, rs1Busy}, {31'b0, expBusy(rs1Addr)});
      checkOutput("rs2_busy", {31'b0, rs2Busy}, {31'b0, expBusy(rs2Addr)});
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Reset state on every address, both ports.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      #1;
      checkOutput("reset_rs1_data", rs1Data, 32'h0);
      checkOutput("reset_rs2_data", rs2Data, 32'h0);
      checkOutput("reset_busy", {30'b0, rs1Busy, rs2Busy}, 32'h0);
      tick();
    end

    // Write x5 with same-cycle bypass, then read back from the array.
    applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    #1; checkOutput("bypass_x5", rs1Data, 32'hDEADBEEF);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 5);
    #1; checkOutput("stored_x5_p1", rs1Data, 32'hDEADBEEF);
    checkOutput("stored_x5_p2", rs2Data, 32'hDEADBEEF);
    tick();

    // x0 write and x0 issue are both dropped.
    applyStimulus(0, 1, 0, 32'h12345678, 1, 0, 0, 0, 0);
    #1; checkOutput("x0_bypass", rs1Data, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; checkOutput("x0_data", rs1Data, 32'h0);
    checkOutput("x0_busy", {31'b0, rs1Busy}, 32'h0);
    tick();

    // Issue x7: busy only from the next cycle, released by writeback.
    applyStimulus(0, 0, 0, 0, 1, 7, 0, 0, 7);
    #1; checkOutput("x7_busy_N", {31'b0, rs2Busy}, 32'h0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7);
      #1; checkOutput("x7_busy_pending", {31'b0, rs2Busy}, 32'h1);
      tick();
    end
    applyStimulus(0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 7);
    #1; checkOutput("x7_wb_busy", {31'b0, rs2Busy}, 32'h0);
    checkOutput("x7_wb_data", rs2Data, 32'hA5A5A5A5);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 7);
    #1; checkOutput("x7_after_busy", {31'b0, rs2Busy}, 32'h0);
    checkOutput("x7_after_data", rs1Data, 32'hA5A5A5A5);
    tick();

    // Same-address writeback and issue: data lands, pending stays set.
    applyStimulus(0, 0, 0, 0, 1, 9, 0, 9, 9);
    tick();
    applyStimulus(0, 1, 9, 32'h1, 1, 9, 0, 9, 9);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 9);
    #1; checkOutput("x9_data", rs1Data, 32'h1);
    checkOutput("x9_busy_kept", {30'b0, rs1Busy, rs2Busy}, 32'h3);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 9);
    #1; checkOutput("x9_flushed_busy", {31'b0, rs1Busy}, 32'h0);
    checkOutput("x9_flushed_data", rs1Data, 32'h1);
    tick();

    // Flush with a concurrent issue: the issue survives, others drop.
    applyStimulus(0, 0, 0, 0, 1, 12, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 14, 32'h0BADF00D, 1, 13, 1, 12, 13);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 12, 13);
    #1; checkOutput("flush_drops_x12", {31'b0, rs1Busy}, 32'h0);
    checkOutput("flush_keeps_x13", {31'b0, rs2Busy}, 32'h1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 14, 0);
    #1; checkOutput("flush_write_x14", rs1Data, 32'h0BADF00D);
    tick();

    // Writes to several addresses while issuing to others.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 5'(20 + i), 32'h1000_0000 + 32'(i), 1, 5'(24 + i), 0, 5'(24 + i), 5'(20 + i));
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 22, 26);
    #1; checkOutput("multi_x22", rs1Data, 32'h1000_0002);
    checkOutput("multi_x26_busy", {31'b0, rs2Busy}, 32'h1);
    tick();

    // Reset mid-pending with a concurrent write that must be ignored.
    applyStimulus(0, 1, 3, 32'hFFFFFFFF, 0, 0, 0, 3, 3);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 3, 0, 3, 3);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 3);
    #1; checkOutput("x3_busy_before_rst", {31'b0, rs1Busy}, 32'h1);
    checkOutput("x3_data_before_rst", rs1Data, 32'hFFFFFFFF);
    tick();
    applyStimulus(1, 1, 3, 32'h55555555, 1, 4, 0, 3, 4);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 4);
    #1; checkOutput("x3_after_rst", rs1Data, 32'h0);
    checkOutput("x3_busy_after_rst", {31'b0, rs1Busy}, 32'h0);
    checkOutput("x4_busy_after_rst", {31'b0, rs2Busy}, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 5);
    #1; checkOutput("x5_after_rst", rs1Data, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
Integer register file for the RV32I core: 32 x 32-bit architectural registers, two combinational read ports for ID and one synchronous write port for WB. It is the read side of the core's writeback path: WB writes, ID reads. An integrated pending-write scoreboard tells ID whether a source operand is still owed by an in-flight multi-cycle producer (load, mul/div), so ID can stall.

Parameters:
XLEN, 32, data word width; equals `word_width.
NREG, 32, number of architectural registers.
AW, 5, register address width; must equal log2(NREG).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset: synchronous, active-high.
rs1_addr  input  AW  read port 1 address.
rs2_addr  input  AW  read port 2 address.
rs1_data  output  XLEN  read port 1 data, combinational.
rs2_data  output  XLEN  read port 2 data, combinational.
rs1_busy  output  1  rs1 has an outstanding pending write.
rs2_busy  output  1  rs2 has an outstanding pending write.
we  input  1  writeback enable.
rd_addr  input  AW  writeback destination.
rd_data  input  XLEN  writeback data.
issue_valid  input  1  a multi-cycle producer is issued this cycle.
issue_rd  input  AW  destination of the issued producer.
flush  input  1  pipeline flush; clears all pending bits.

Behaviour:
- Reset: on a rising edge with rst=1, all registers clear to 0 and all pending bits clear to 0, in one cycle. Outputs then read 0 and busy=0. rst overrides we, issue_valid and flush in the same cycle.
- x0 handling:
  - Reads of address 0 always return 0 and busy=0.
  - Writes to address 0 are dropped.
  - issue_rd=0 never sets a pending bit.
- Write: on a rising edge with we=1 and rd_addr!=0, regs[rd_addr] <= rd_data. The same edge clears pending[rd_addr], unless an issue to the same address also occurs (see simultaneous events).
- Read (combinational, zero latency): rsN_data = 0 if rsN_addr=0; else rd_data if we and rd_addr=rsN_addr (write-first bypass); else regs[rsN_addr].
- Busy (combinational): rsN_busy = pending[rsN_addr] and not (we and rd_addr=rsN_addr) and rsN_addr!=0. A same-cycle writeback therefore releases the stall in that cycle.
- Issue: on a rising edge with issue_valid=1 and issue_rd!=0, pending[issue_rd] <= 1. The new bit is visible on busy from the next cycle only; there is no same-cycle issue bypass.
- Simultaneous events on the same rising edge:
  - we and issue_valid to the same address: data is written and pending is left set, because the newer producer wins.
  - Different addresses: both take effect independently.
  - rs1_addr = rs2_addr: both ports return identical data and busy.
- Flush: on a rising edge, pending <= 0 for all entries. Register contents are unaffected. If flush and issue_valid occur together, the issue still sets its bit (the issued instruction is post-flush). we in the same cycle still writes.
- A write with no matching pending bit is legal and leaves pending unchanged.
- No X propagation: every output is a defined function of state and inputs at all times after the first reset.

Decomposition:
- parameters.vh gains `reg_addr_width (5) and `num_regs (32), alongside the existing `word_width. No new typedefs.
- One sub-module, rf_scoreboard: NREG-bit pending vector with issue-set, writeback-clear, flush and reset. It exposes pending[] and is instantiated once.
- The register array and bypass read muxes stay in the top module.

Test Plan:
1. Reset, then read all 32 addresses on both ports -> every rs*_data = 0x00000000, every rs*_busy = 0.
2. Write x5=0xDEADBEEF with rs1_addr=5 in the same cycle -> rs1_data = 0xDEADBEEF that cycle (bypass) and on every later cycle with we=0.
3. Write x0=0x12345678 and issue_rd=0 -> rs1_data for addr 0 reads 0x00000000, rs1_busy = 0.
4. Issue rd=7 at cycle N -> rs2_busy(7) = 0 at N and 1 at N+1..N+3. Then we rd=7, data 0xA5A5A5A5 at N+4 -> busy = 0 and data = 0xA5A5A5A5 in N+4, and busy stays 0 after.
5. Issue rd=9, then same-cycle we rd=9 data 0x1 plus issue rd=9 -> data reads 0x1 and busy remains 1 the next cycle. Then a flush -> busy(9) = 0 and data still 0x1.
6. Write x3=0xFFFFFFFF, issue rd=3, then assert rst mid-pending -> next cycle x3 reads 0x00000000, busy(3) = 0. A same-cycle we to x3 during rst is ignored.
